// File: rtl/switch_alloc_rr.sv
// Per-output wormhole switch allocator: registered round-robin grant held until the owner's tail transfers.
// Optional lock watchdog enabled by defining SWITCH_ALLOC_WATCHDOG_EN.
module switch_alloc_rr #(
  parameter int PORTS        = 4,
  parameter int SEL_W        = $clog2(PORTS),
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_i,
  input  logic [PORTS-1:0][SEL_W-1:0] req_dst_i,
  input  logic [PORTS-1:0]            xfer_i,
  input  logic [PORTS-1:0]            tail_i,
  output logic [PORTS-1:0]            gnt_o,
  output logic [PORTS-1:0][SEL_W-1:0] gnt_dst_o,
  output logic [PORTS-1:0]            out_busy_o,
  output logic [PORTS-1:0][SEL_W-1:0] out_sel_o,
  output logic                        err_o
);

  typedef enum logic {FREE, LOCKED} state_t;

  state_t           state   [PORTS];
  logic [SEL_W-1:0] ptr     [PORTS];
  logic [SEL_W-1:0] own     [PORTS];
  logic [SEL_W-1:0] win_idx [PORTS];
  logic [PORTS-1:0] win_vld;
  logic [PORTS-1:0] owner_xfer;
  logic [PORTS-1:0] owner_tail;
  logic [PORTS-1:0] wd_fire;

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      owner_xfer[o] = xfer_i[own[o]];
      owner_tail[o] = tail_i[own[o]];
    end
  end

  // Scan from the farthest candidate back to ptr so the last hit is the round-robin winner.
  // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    int cand;
    cand = 0;
    for (int o = 0; o < PORTS; o++) begin
      win_vld[o] = 1'b0;
      win_idx[o] = '0;
      if (state[o] == FREE) begin
        for (int k = PORTS - 1; k >= 0; k--) begin
          cand = (int'(ptr[o]) + k) % PORTS;
          if (req_i[cand] && !gnt_o[cand] && req_dst_i[cand] == SEL_W'(o)) begin
            win_vld[o] = 1'b1;
            win_idx[o] = SEL_W'(cand);
          end
        end
      end
    end
  end

  // A winning input is never a current owner, so release and win writes to gnt_o never collide.
  // NOTE: sequential state uses non-blocking assignments so every output decision sees pre-edge values.
  // NOTE: ptr and own are reset like any other flop; post-reset fairness depends on ptr starting at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_o      <= '0;
      gnt_dst_o  <= '0;
      out_busy_o <= '0;
      out_sel_o  <= '0;
      for (int o = 0; o < PORTS; o++) begin
        state[o] <= FREE;
        ptr[o]   <= '0;
        own[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        if (state[o] == LOCKED) begin
          if ((owner_xfer[o] && owner_tail[o]) || wd_fire[o]) begin
            state[o]             <= FREE;
            own[o]               <= '0;
            out_busy_o[o]        <= 1'b0;
            out_sel_o[o]         <= '0;
            gnt_o[own[o]]        <= 1'b0;
            gnt_dst_o[own[o]]    <= '0;
          end
        end else if (win_vld[o]) begin
          state[o]              <= LOCKED;
          own[o]                <= win_idx[o];
          ptr[o]                <= SEL_W'((int'(win_idx[o]) + 1) % PORTS);
          out_busy_o[o]         <= 1'b1;
          out_sel_o[o]          <= win_idx[o];
          gnt_o[win_idx[o]]     <= 1'b1;
          gnt_dst_o[win_idx[o]] <= SEL_W'(o);
        end
      end
    end
  end

`ifdef SWITCH_ALLOC_WATCHDOG_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt [PORTS];

  // Fires on the edge that would make the idle count reach LOCK_TIMEOUT.
  always_comb begin
    for (int o = 0; o < PORTS; o++)
      wd_fire[o] = (state[o] == LOCKED) && !owner_xfer[o] &&
                   (wd_cnt[o] == CNT_W'(LOCK_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
      for (int o = 0; o < PORTS; o++) wd_cnt[o] <= '0;
    end else begin
      err_o <= |wd_fire;
      for (int o = 0; o < PORTS; o++) begin
        if (state[o] != LOCKED || owner_xfer[o] || wd_fire[o]) wd_cnt[o] <= '0;
        else                                                   wd_cnt[o] <= wd_cnt[o] + 1'b1;
      end
    end
  end
`else
  assign wd_fire = '0;
  // LOCK_TIMEOUT only matters with the watchdog; this folds to a constant 0.
  assign err_o   = (LOCK_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Self-checking bench for switch_alloc_rr: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_switch_alloc_rr;
  localparam int PORTS        = 4;
  localparam int SEL_W        = 2;
  localparam int LOCK_TIMEOUT = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [PORTS-1:0]            req_i    = '0;
  logic [PORTS-1:0][SEL_W-1:0] req_dst_i = '0;
  logic [PORTS-1:0]            xfer_i   = '0;
  logic [PORTS-1:0]            tail_i   = '0;
  logic [PORTS-1:0]            gnt_o;
  logic [PORTS-1:0][SEL_W-1:0] gnt_dst_o;
  logic [PORTS-1:0]            out_busy_o;
  logic [PORTS-1:0][SEL_W-1:0] out_sel_o;
  logic                        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_alloc_rr #(.PORTS(PORTS), .SEL_W(SEL_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_dst_i (req_dst_i),
    .xfer_i    (xfer_i),
    .tail_i    (tail_i),
    .gnt_o     (gnt_o),
    .gnt_dst_o (gnt_dst_o),
    .out_busy_o(out_busy_o),
    .out_sel_o (out_sel_o),
    .err_o     (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner per output (-1 = free) and the next input to favour.
  int m_own [PORTS];
  int m_ptr [PORTS];
  bit m_err;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
  int m_idle [PORTS];
`endif

  task automatic model_step();
    int nown [PORTS];
    bit held [PORTS];
    bit nerr;
    nerr = 1'b0;
    for (int i = 0; i < PORTS; i++) held[i] = 1'b0;
    for (int o = 0; o < PORTS; o++) begin
      nown[o] = m_own[o];
      if (m_own[o] >= 0) held[m_own[o]] = 1'b1;
    end
    for (int o = 0; o < PORTS; o++) begin
      if (m_own[o] >= 0) begin
        int w = m_own[o];
        if (xfer_i[w] && tail_i[w]) nown[o] = -1;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
        if (xfer_i[w]) m_idle[o] = 0;
        else if (m_idle[o] + 1 >= LOCK_TIMEOUT) begin
          nown[o] = -1; m_idle[o] = 0; nerr = 1'b1;
        end else m_idle[o]++;
`endif
      end else begin
        for (int k = 0; k < PORTS && nown[o] < 0; k++) begin
          int i = (m_ptr[o] + k) % PORTS;
          if (req_i[i] && int'(req_dst_i[i]) == o && !held[i]) begin
            nown[o]  = i;
            m_ptr[o] = (i + 1) % PORTS;
          end
        end
`ifdef SWITCH_ALLOC_WATCHDOG_EN
        m_idle[o] = 0;
`endif
      end
    end
    for (int o = 0; o < PORTS; o++) m_own[o] = nown[o];
    m_err = nerr;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORTS; o++) begin
        m_own[o] = -1;
        m_ptr[o] = 0;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
        m_idle[o] = 0;
`endif
      end
      m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic compare_all();
    logic [PORTS-1:0]            eg, eb;
    logic [PORTS-1:0][SEL_W-1:0] ed, es;
    eg = '0; eb = '0; ed = '0; es = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (m_own[o] >= 0) begin
        eb[o]        = 1'b1;
        es[o]        = SEL_W'(m_own[o]);
        eg[m_own[o]] = 1'b1;
        ed[m_own[o]] = SEL_W'(o);
      end
    end
    check("model_gnt",     64'(gnt_o),      64'(eg));
    check("model_gnt_dst", 64'(gnt_dst_o),  64'(ed));
    check("model_busy",    64'(out_busy_o), 64'(eb));
    check("model_sel",     64'(out_sel_o),  64'(es));
    check("model_err",     64'(err_o),      64'(m_err));
  endtask

  always @(posedge clk) begin
    #2;
    if (rst === 1'b0) compare_all();
  end

  task automatic next_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    req_i = '0; req_dst_i = '0; xfer_i = '0; tail_i = '0;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    next_edge();
  endtask

  int seq [$];
  int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
  int flits [PORTS];
  int gaps;

  initial begin
    do_reset();
    check("reset_gnt",  64'(gnt_o),      64'h0);
    check("reset_dst",  64'(gnt_dst_o),  64'h0);
    check("reset_busy", 64'(out_busy_o), 64'h0);
    check("reset_sel",  64'(out_sel_o),  64'h0);
    check("reset_err",  64'(err_o),      64'h0);

    // Single request: input 0 to output 2, tail four edges later.
    req_dst_i[0] = 2'd2; req_i = 4'b0001;
    next_edge();
    check("single_gnt",  64'(gnt_o),      64'h1);
    check("single_dst",  64'(gnt_dst_o),  64'h02);
    check("single_sel",  64'(out_sel_o),  64'h00);
    check("single_busy", 64'(out_busy_o), 64'h4);
    req_i = '0; xfer_i = 4'b0001;
    repeat (3) next_edge();
    check("single_hold", 64'(out_busy_o), 64'h4);
    tail_i = 4'b0001;
    next_edge();
    check("single_free_gnt",  64'(gnt_o),      64'h0);
    check("single_free_busy", 64'(out_busy_o), 64'h0);
    check("single_free_dst",  64'(gnt_dst_o),  64'h0);
    xfer_i = '0; tail_i = '0;

    // Parallel grants: 0->1, 1->2, 2->3, 3->0.
    do_reset();
    req_dst_i = 8'b00_11_10_01; req_i = 4'b1111;
    next_edge();
    check("par_busy", 64'(out_busy_o), 64'hF);
    check("par_gnt",  64'(gnt_o),      64'hF);
    check("par_dst",  64'(gnt_dst_o),  64'h39);
    check("par_sel",  64'(out_sel_o),  64'h93);

    // Lock hold: owner drops req while another input waits for the same output.
    do_reset();
    req_dst_i[2] = 2'd3; req_i = 4'b0100;
    next_edge();
    check("hold_first_gnt", 64'(gnt_o),     64'h4);
    check("hold_first_sel", 64'(out_sel_o), 64'h80);
    req_dst_i[0] = 2'd3; req_i = 4'b0001; xfer_i = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      next_edge();
      check("hold_gnt",  64'(gnt_o),      64'h4);
      check("hold_busy", 64'(out_busy_o), 64'h8);
    end
    tail_i = 4'b0100;
    next_edge();
    check("hold_bubble_gnt",  64'(gnt_o),      64'h0);
    check("hold_bubble_busy", 64'(out_busy_o), 64'h0);
    xfer_i = '0; tail_i = '0;
    next_edge();
    check("hold_next_gnt",  64'(gnt_o),      64'h1);
    check("hold_next_sel",  64'(out_sel_o),  64'h00);
    check("hold_next_busy", 64'(out_busy_o), 64'h8);

    // Contention: inputs 0, 1, 3 stream 2-flit packets into output 1.
    do_reset();
    req_dst_i[0] = 2'd1; req_dst_i[1] = 2'd1; req_dst_i[3] = 2'd1;
    req_i = 4'b1011;
    for (int i = 0; i < PORTS; i++) flits[i] = 0;
    gaps = 0;
    seq.delete();
    for (int c = 0; c < 40 && seq.size() < 6; c++) begin
      next_edge();
      if (out_busy_o[1] && (seq.size() == 0 || gnt_o[seq[$]] == 1'b0 || flits[out_sel_o[1]] == 0))
        if (flits[out_sel_o[1]] == 0) seq.push_back(int'(out_sel_o[1]));
      if (!out_busy_o[1] && seq.size() > 0) gaps++;
      for (int i = 0; i < PORTS; i++) begin
        if (gnt_o[i]) begin
          xfer_i[i] = 1'b1;
          tail_i[i] = (flits[i] == 1);
          flits[i]++;
        end else begin
          xfer_i[i] = 1'b0;
          tail_i[i] = 1'b0;
          flits[i]  = 0;
        end
      end
    end
    check("fair_count", 64'(seq.size()), 64'd6);
    for (int k = 0; k < 6 && k < seq.size(); k++) check("fair_owner", 64'(seq[k]), 64'(exp_seq[k]));
    check("fair_gaps", 64'(gaps), 64'd5);

    // Async reset between edges with three outputs locked.
    do_reset();
    req_dst_i = 8'b00_11_10_01; req_i = 4'b0111;
    next_edge();
    check("arst_locked", 64'(out_busy_o), 64'hE);
    req_i = '0;
    next_edge();
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt",  64'(gnt_o),      64'h0);
    check("arst_busy", 64'(out_busy_o), 64'h0);
    check("arst_sel",  64'(out_sel_o),  64'h0);
    check("arst_dst",  64'(gnt_dst_o),  64'h0);
    #1;
    rst = 1'b0;
    req_dst_i[0] = 2'd1; req_dst_i[3] = 2'd1; req_i = 4'b1001;
    next_edge();
    check("arst_first_gnt",  64'(gnt_o),      64'h1);
    check("arst_first_busy", 64'(out_busy_o), 64'h2);

    // Watchdog: owner of output 0 stalls with no transfers.
    do_reset();
    req_dst_i[1] = 2'd0; req_i = 4'b0010;
    next_edge();
    req_i = '0;
`ifdef SWITCH_ALLOC_WATCHDOG_EN
    for (int k = 1; k <= 10; k++) begin
      next_edge();
      check("wd_err",  64'(err_o),         64'(k == 8));
      check("wd_busy", 64'(out_busy_o[0]), 64'(k < 8));
    end
`else
    for (int k = 1; k <= 20; k++) begin
      next_edge();
      check("nowd_err",  64'(err_o),         64'h0);
      check("nowd_busy", 64'(out_busy_o[0]), 64'h1);
    end
`endif

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_i     = 4'($urandom);
      req_dst_i = 8'($urandom);
      xfer_i    = 4'($urandom) | 4'($urandom);
      tail_i    = 4'($urandom) & 4'($urandom);
      next_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
